// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: holds ALU result, store data, rd and mem/wb control; latency 1 cycle.
// Backpressure: with EX_MEM_SKID_EN a main+skid pair gives a registered in_ready; without it one slot, in_ready = !out_valid || out_ready.
module ex_mem_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_alu_result,
   input  logic [DATA_WIDTH-1:0]     in_store_data,
   input  logic [DATA_WIDTH-1:0]     in_pc_plus4,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic                      in_reg_write,
   input  logic                      in_mem_read,
   input  logic                      in_mem_write,
   input  logic [1:0]                in_mem_to_reg,
   input  logic [2:0]                in_funct3,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_alu_result,
   output logic [DATA_WIDTH-1:0]     out_store_data,
   output logic [DATA_WIDTH-1:0]     out_pc_plus4,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic                      out_reg_write,
   output logic                      out_mem_read,
   output logic                      out_mem_write,
   output logic [1:0]                out_mem_to_reg,
   output logic [2:0]                out_funct3
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     alu_result;
      logic [DATA_WIDTH-1:0]     store_data;
      logic [DATA_WIDTH-1:0]     pc_plus4;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      reg_write;
      logic                      mem_read;
      logic                      mem_write;
      logic [1:0]                mem_to_reg;
      logic [2:0]                funct3;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t state, state_nxt;
   entry_t main_q, in_entry;
   logic   in_fire, out_fire, load_main;

   // x0 is hardwired to zero, so a write to it is dropped at capture
   always_comb begin
      in_entry.alu_result = in_alu_result;
      in_entry.store_data = in_store_data;
      in_entry.pc_plus4   = in_pc_plus4;
      in_entry.rd         = in_rd;
      in_entry.reg_write  = in_reg_write && (in_rd != '0);
      in_entry.mem_read   = in_mem_read;
      in_entry.mem_write  = in_mem_write;
      in_entry.mem_to_reg = in_mem_to_reg;
      in_entry.funct3     = in_funct3;
   end

   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

`ifdef EX_MEM_SKID_EN
   entry_t skid_q;
   logic   load_skid, skid_to_main;

   always_comb begin
      state_nxt    = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  state_nxt = TWO;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               state_nxt    = ONE;
               skid_to_main = 1'b1;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // in_ready is computed from the next state so it never depends on out_ready combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         main_q   <= '0;
         skid_q   <= '0;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != TWO);
         if (load_main)
            main_q <= in_entry;
         else if (skid_to_main)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= in_entry;
      end
   end
`else
   assign in_ready = (state == EMPTY) || out_ready;

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
            ONE: begin
               if (in_fire)
                  load_main = 1'b1;
               else if (out_fire)
                  state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_main)
            main_q <= in_entry;
      end
   end
`endif

   assign out_alu_result = main_q.alu_result;
   assign out_store_data = main_q.store_data;
   assign out_pc_plus4   = main_q.pc_plus4;
   assign out_rd         = main_q.rd;
   assign out_reg_write  = main_q.reg_write;
   assign out_mem_read   = main_q.mem_read;
   assign out_mem_write  = main_q.mem_write;
   assign out_mem_to_reg = main_q.mem_to_reg;
   assign out_funct3     = main_q.funct3;

endmodule
